// File: rtl/perf_counter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// perf_ctr_pkg
//   Shared definitions for the performance counter controller:
//   - default bank geometry and bus widths
//   - bus FSM state encoding (legacy constant values backing an enum)
//   - register offsets of the ENABLE and OVF words that follow the counters
// ---------------------------------------------------------------------------
package perf_ctr_pkg;

   localparam int unsigned DEF_NUM_CTRS  = 8;
   localparam int unsigned DEF_CTR_WIDTH = 16;
   localparam int unsigned ADDR_W        = 4;
   localparam int unsigned DATA_W        = 32;

   // Legacy encodings kept so existing decode/trace tooling sees the same values.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      RESP = ST_RESP
   } bus_state_t;

   // ENABLE sits directly after the last counter, OVF after ENABLE.
   function automatic int unsigned ENABLE_OFS(input int unsigned n);
      return n;
   endfunction

   function automatic int unsigned OVF_OFS(input int unsigned n);
      return n + 1;
   endfunction

endpackage

// File: rtl/perf_counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// perf_counter_ctrl_if
//   Word-addressed MMIO request/response port.
//   mem_read     request: read  (held until mem_resp)
//   mem_write    request: write (held until mem_resp)
//   mem_address  word index
//   mem_wdata    write data
//   mem_rdata    read data, valid while mem_resp=1
//   mem_resp     single-cycle completion pulse
//   master: requester side; slave: the counter controller.
// ---------------------------------------------------------------------------
interface perf_counter_ctrl_if;
   import perf_ctr_pkg::*;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_resp;

   modport master (
      output mem_read,
      output mem_write,
      output mem_address,
      output mem_wdata,
      input  mem_rdata,
      input  mem_resp
   );

   modport slave (
      input  mem_read,
      input  mem_write,
      input  mem_address,
      input  mem_wdata,
      output mem_rdata,
      output mem_resp
   );

endinterface

// File: rtl/perf_counter_ctrl_slot.sv
// ---------------------------------------------------------------------------
// perf_ctr_slot
//   One performance counter: rising-edge detector, enable gate, wrapping
//   counter and sticky overflow flag.
//   clk        system clock
//   rst        synchronous active-high reset
//   event_i    raw event line; a 0->1 transition counts
//   enable_i   gate for this counter (registered enable of the bank)
//   clear_i    clears counter and overflow; beats a same-edge increment
//   ovf_clr_i  clears the overflow flag unless a wrap happens on that edge
//   ctr_o      current count
//   ovf_o      sticky overflow flag
// ---------------------------------------------------------------------------
module perf_ctr_slot
   import perf_ctr_pkg::*;
#(
   parameter int unsigned CTR_WIDTH = DEF_CTR_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 event_i,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic                 ovf_clr_i,
   output logic [CTR_WIDTH-1:0] ctr_o,
   output logic                 ovf_o
);

   logic                 prev_q;
   logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
   logic                 ovf_q, ovf_d;
   logic                 rise;
   logic                 wrap;

   always_comb begin
      rise  = event_i & ~prev_q & enable_i;
      wrap  = rise & (ctr_q == '1);
      ctr_d = ctr_q;
      ovf_d = ovf_q;
      if (clear_i) begin
         // Clear drops any coincident event, so no wrap can be flagged either.
         ctr_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (rise) begin
            ctr_d = ctr_q + CTR_WIDTH'(1);
         end
         // A new wrap outranks a coincident write-1-to-clear.
         if (wrap) begin
            ovf_d = 1'b1;
         end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
         end
      end
   end

   // prev resets high so a line already asserted at reset release is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b1;
         ctr_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         prev_q <= event_i;
         ctr_q  <= ctr_d;
         ovf_q  <= ovf_d;
      end
   end

   assign ctr_o = ctr_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_ctrl.sv
// ---------------------------------------------------------------------------
// perf_counter_ctrl
//   Bank of NUM_CTRS event counters behind a word-addressed MMIO slave port.
//   Address map: 0..NUM_CTRS-1 counters, NUM_CTRS ENABLE mask,
//   NUM_CTRS+1 OVF mask (write-1-to-clear). Writing a counter address clears
//   that counter and its overflow flag; the write data is ignored.
//   clk       system clock
//   rst       synchronous active-high reset
//   event_in  event lines, one per counter
//   bus       MMIO slave port (mem_read/mem_write/mem_address/mem_wdata in,
//             mem_rdata/mem_resp out)
//   Each access is accepted in IDLE and answered by a one-cycle mem_resp in
//   RESP; requests seen while in RESP are ignored.
// ---------------------------------------------------------------------------
module perf_counter_ctrl
   import perf_ctr_pkg::*;
#(
   parameter int unsigned NUM_CTRS  = DEF_NUM_CTRS,
   parameter int unsigned CTR_WIDTH = DEF_CTR_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CTRS-1:0]  event_in,
   perf_counter_ctrl_if.slave   bus
);

   localparam logic [ADDR_W-1:0] ENA_ADDR = ADDR_W'(ENABLE_OFS(NUM_CTRS));
   localparam logic [ADDR_W-1:0] OVF_ADDR = ADDR_W'(OVF_OFS(NUM_CTRS));

   bus_state_t                         state_q, state_d;
   logic [NUM_CTRS-1:0]                enable_q, enable_d;
   logic [DATA_W-1:0]                  rdata_q, rdata_d;

   logic [NUM_CTRS-1:0][CTR_WIDTH-1:0] ctr;
   logic [NUM_CTRS-1:0]                ovf;
   logic [NUM_CTRS-1:0]                clear;
   logic [NUM_CTRS-1:0]                ovf_clr;

   logic                               accept;
   logic                               do_wr;
   logic                               do_rd;
   logic [DATA_W-1:0]                  rd_mux;
   logic                               unused_wdata;

   // A combined read+write performs only the write and returns zero.
   always_comb begin
      accept = (state_q == IDLE) & (bus.mem_read | bus.mem_write);
      do_wr  = accept & bus.mem_write;
      do_rd  = accept & bus.mem_read & ~bus.mem_write;
   end

   // Read mux; unmapped addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
         if (bus.mem_address == ADDR_W'(i)) begin
            rd_mux = DATA_W'(ctr[i]);
         end
      end
      if (bus.mem_address == ENA_ADDR) begin
         rd_mux = DATA_W'(enable_q);
      end
      if (bus.mem_address == OVF_ADDR) begin
         rd_mux = DATA_W'(ovf);
      end
   end

   // Per-slot write strobes.
   always_comb begin
      clear   = '0;
      ovf_clr = '0;
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
         clear[i]   = do_wr & (bus.mem_address == ADDR_W'(i));
         ovf_clr[i] = do_wr & (bus.mem_address == OVF_ADDR) & bus.mem_wdata[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      enable_d = enable_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RESP;
               rdata_d = do_rd ? rd_mux : '0;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // The slots see enable_q, so a new mask only gates events from the next edge.
      if (do_wr && (bus.mem_address == ENA_ADDR)) begin
         enable_d = bus.mem_wdata[NUM_CTRS-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         enable_q <= '1;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
         rdata_q  <= rdata_d;
      end
   end

   for (genvar g = 0; g < NUM_CTRS; g++) begin : g_slot
      perf_ctr_slot #(
         .CTR_WIDTH (CTR_WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .event_i   (event_in[g]),
         .enable_i  (enable_q[g]),
         .clear_i   (clear[g]),
         .ovf_clr_i (ovf_clr[g]),
         .ctr_o     (ctr[g]),
         .ovf_o     (ovf[g])
      );
   end

   // Upper write-data bits have no destination in this register map.
   assign unused_wdata = ^bus.mem_wdata[DATA_W-1:NUM_CTRS];

   assign bus.mem_rdata = rdata_q;
   assign bus.mem_resp  = (state_q == RESP);

endmodule
